// File: rtl/id_arb_pkg.sv
// Shared definitions for the id_arb block: character-class bounds,
// recognizer and controller state encodings, and class-decode helpers.
package id_arb_pkg;

   // Character-class bounds (ASCII)
   localparam logic [7:0] UPPER_LO = 8'h41;
   localparam logic [7:0] UPPER_HI = 8'h5A;
   localparam logic [7:0] LOWER_LO = 8'h61;
   localparam logic [7:0] LOWER_HI = 8'h7A;
   localparam logic [7:0] DIGIT_LO = 8'h30;
   localparam logic [7:0] DIGIT_HI = 8'h39;

   // Recognizer states: S2 means "letter followed by one or more digits"
   typedef enum logic [1:0] {
      RS_S0 = 2'd0,
      RS_S1 = 2'd1,
      RS_S2 = 2'd2
   } rec_state_t;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } ctl_state_t;

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= UPPER_LO) && (c <= UPPER_HI)) ||
             ((c >= LOWER_LO) && (c <= LOWER_HI));
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= DIGIT_LO) && (c <= DIGIT_HI);
   endfunction

endpackage

// File: rtl/id_recog.sv
// Identifier recognizer: classifies each accepted character and walks the
// S0/S1/S2 state machine. clr has priority over en so a new frame always
// starts from S0.
module id_recog
   import id_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] char,
   output rec_state_t state
);

   rec_state_t r_state;
   rec_state_t w_nxt;
   logic       w_letter;
   logic       w_digit;

   assign w_letter = is_letter(char);
   assign w_digit  = is_digit(char);

   // Next-state decode from the current character class
   always_comb begin
      w_nxt = r_state;
      if (clr) begin
         w_nxt = RS_S0;
      end else if (en) begin
         case (r_state)
            RS_S0:   w_nxt = w_letter ? RS_S1 : RS_S0;
            RS_S1,
            RS_S2:   w_nxt = w_digit  ? RS_S2 :
                             w_letter ? RS_S1 : RS_S0;
            default: w_nxt = RS_S0;
         endcase
      end
   end

   // Recognizer state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= RS_S0;
      else       r_state <= w_nxt;
   end

   assign state = r_state;

endmodule

// File: rtl/id_arb.sv
// Round-robin arbiter/sequencer sharing one id_recog between two character
// streams. Grants one whole frame at a time and emits a one-cycle result
// pulse with hit, length and channel.
// Optional feature: define ID_ARB_TIMEOUT_EN to abort frames whose granted
// channel stalls for TIMEOUT consecutive cycles.
module id_arb
   import id_arb_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [7:0]       req0_char,
   input  logic             req0_last,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [7:0]       req1_char,
   input  logic             req1_last,
   output logic             req1_ready,
   output logic             res_valid,
   output logic             res_ch,
   output logic             res_hit,
   output logic [LEN_W-1:0] res_len,
   output logic             res_abort,
   output logic             busy
);

   ctl_state_t       r_state;
   ctl_state_t       w_nxt;
   logic             r_last_gnt;   // also the currently granted channel
   logic [LEN_W-1:0] r_len;
   logic             r_res_ch;
   logic             r_res_hit;
   logic [LEN_W-1:0] r_res_len;
   logic             r_res_abort;

   logic             w_valid;
   logic [7:0]       w_char;
   logic             w_last;
   logic             w_acc;
   logic             w_grant;
   logic             w_gnt_ch;
   logic             w_to_hit;
   logic             w_abort;
   logic             w_hit;
   rec_state_t       w_rec;

   // Mux the granted channel onto the shared datapath
   assign w_valid  = r_last_gnt ? req1_valid : req0_valid;
   assign w_char   = r_last_gnt ? req1_char  : req0_char;
   assign w_last   = r_last_gnt ? req1_last  : req0_last;

   assign w_acc    = (r_state == ST_BUSY) && w_valid;
   assign w_grant  = (r_state == ST_IDLE) && (req0_valid || req1_valid);
   // Contention goes to the channel that was not granted last time
   assign w_gnt_ch = (req0_valid && req1_valid) ? ~r_last_gnt : req1_valid;

   assign req0_ready = (r_state == ST_BUSY) && !r_last_gnt;
   assign req1_ready = (r_state == ST_BUSY) &&  r_last_gnt;

`ifdef ID_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] r_to;
   logic            r_abort;

   assign w_to_hit = (r_state == ST_BUSY) && !w_valid &&
                     (r_to == TO_W'(TIMEOUT - 1));
   assign w_abort  = r_abort;

   // Stall counter: counts idle cycles of the granted channel
   always_ff @(posedge clk) begin
      if (reset || w_grant || w_acc) r_to <= '0;
      else if (r_state == ST_BUSY)   r_to <= r_to + TO_W'(1);
   end

   // Abort flag for the frame in flight
   always_ff @(posedge clk) begin
      if (reset || w_grant) r_abort <= 1'b0;
      else if (w_to_hit)    r_abort <= 1'b1;
   end
`else
   logic w_unused_to;

   assign w_to_hit    = 1'b0;
   assign w_abort     = 1'b0;
   assign w_unused_to = (TIMEOUT != 0);
`endif

   id_recog u_recog (
      .clk   (clk),
      .reset (reset),
      .clr   (w_grant),
      .en    (w_acc),
      .char  (w_char),
      .state (w_rec)
   );

   assign w_hit = (w_rec == RS_S2) && !w_abort;

   // Controller next-state logic
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE: if (req0_valid || req1_valid) w_nxt = ST_BUSY;
         ST_BUSY: if ((w_acc && w_last) || w_to_hit) w_nxt = ST_DONE;
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   // Controller state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_nxt;
   end

   // Grant pointer; reset to 1 so channel 0 wins the first contention
   always_ff @(posedge clk) begin
      if (reset)        r_last_gnt <= 1'b1;
      else if (w_grant) r_last_gnt <= w_gnt_ch;
   end

   // Saturating frame length counter
   always_ff @(posedge clk) begin
      if (reset || w_grant)              r_len <= '0;
      else if (w_acc && (r_len != '1))   r_len <= r_len + LEN_W'(1);
   end

   // Hold the result past DONE until the next frame completes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_res_ch    <= 1'b0;
         r_res_hit   <= 1'b0;
         r_res_len   <= '0;
         r_res_abort <= 1'b0;
      end else if (r_state == ST_DONE) begin
         r_res_ch    <= r_last_gnt;
         r_res_hit   <= w_hit;
         r_res_len   <= r_len;
         r_res_abort <= w_abort;
      end
   end

   // In DONE the live frame state is still intact, so present it directly;
   // afterwards the held copy keeps the outputs stable.
   assign res_valid = (r_state == ST_DONE);
   assign res_ch    = res_valid ? r_last_gnt : r_res_ch;
   assign res_hit   = res_valid ? w_hit      : r_res_hit;
   assign res_len   = res_valid ? r_len      : r_res_len;
   assign res_abort = res_valid ? w_abort    : r_res_abort;
   assign busy      = (r_state == ST_BUSY) || (r_state == ST_DONE);

endmodule

// File: tb/tb_id_arb.sv
// Directed testbench for id_arb. Inputs change 1 time unit after the rising
// edge; outputs are sampled there or on the falling edge.
module tb_id_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_char;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_char;
   logic       res_valid, res_ch, res_hit, res_abort, busy;
   logic [7:0] res_len;

   int errs   = 0;
   int checks = 0;

   typedef struct {
      logic       ch;
      logic       hit;
      logic       abort;
      logic [7:0] len;
   } res_t;
   res_t q[$];

   always #5 clk = ~clk;

   id_arb #(.LEN_W(8), .TIMEOUT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_char  (req0_char),
      .req0_last  (req0_last),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_char  (req1_char),
      .req1_last  (req1_last),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ch     (res_ch),
      .res_hit    (res_hit),
      .res_len    (res_len),
      .res_abort  (res_abort),
      .busy       (busy)
   );

   // Record every result pulse
   always @(negedge clk) begin
      if (res_valid) q.push_back('{ch: res_ch, hit: res_hit, abort: res_abort, len: res_len});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit ch, input bit v, input logic [7:0] c, input bit l);
      if (ch) begin req1_valid = v; req1_char = c; req1_last = l; end
      else    begin req0_valid = v; req0_char = c; req0_last = l; end
   endtask

   function automatic logic rdy(input bit ch);
      return ch ? req1_ready : req0_ready;
   endfunction

   // Send a whole frame on one channel, one character per accept
   task automatic send(input bit ch, input string s);
      for (int i = 0; i < s.len(); i++) begin
         int w = 0;
         drive(ch, 1'b1, s[i], i == s.len() - 1);
         while (!rdy(ch) && w < 100) begin tick(); w++; end
         if (w >= 100) begin
            checks++; errs++;
            $display("FAIL send_wait ch%0d char %0d: ready never rose, required 1", ch, i);
         end
         tick();
      end
      drive(ch, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 8'h00, 0);
      drive(1, 0, 8'h00, 0);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errs++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
      checks++; if ({res_valid, res_ch, res_hit, res_abort, busy} !== 5'b0) begin errs++; $display("FAIL reset_flags got=%b exp=00000", {res_valid, res_ch, res_hit, res_abort, busy}); end
      checks++; if (res_len !== 8'd0) begin errs++; $display("FAIL reset_len got=%0d exp=0", res_len); end
   endtask

   task automatic test_single_ch0();
      drive(0, 1, "a", 0);
      checks++; if (req0_ready !== 1'b0) begin errs++; $display("FAIL idle_ready got=%b exp=0", req0_ready); end
      tick();
      checks++; if ({req0_ready, req1_ready, busy} !== 3'b101) begin errs++; $display("FAIL grant_latency got=%b exp=101", {req0_ready, req1_ready, busy}); end
      send(0, "ab12");
      checks++; if (res_valid !== 1'b1) begin errs++; $display("FAIL ab12_valid got=%b exp=1", res_valid); end
      checks++; if ({res_ch, res_hit, res_abort} !== 3'b010) begin errs++; $display("FAIL ab12_flags got=%b exp=010", {res_ch, res_hit, res_abort}); end
      checks++; if (res_len !== 8'd4) begin errs++; $display("FAIL ab12_len got=%0d exp=4", res_len); end
      tick();
      checks++; if ({res_valid, busy} !== 2'b00) begin errs++; $display("FAIL ab12_pulse got=%b exp=00", {res_valid, busy}); end
      checks++; if (res_len !== 8'd4 || res_hit !== 1'b1) begin errs++; $display("FAIL ab12_hold got len=%0d hit=%b exp len=4 hit=1", res_len, res_hit); end
   endtask

   task automatic test_ch1();
      send(1, "12");
      checks++; if ({res_valid, res_ch, res_hit, res_len} !== {3'b110, 8'd2}) begin errs++; $display("FAIL s12 got v=%b ch=%b hit=%b len=%0d exp v=1 ch=1 hit=0 len=2", res_valid, res_ch, res_hit, res_len); end
      tick();
      send(1, "a1b");
      checks++; if ({res_valid, res_ch, res_hit, res_len} !== {3'b110, 8'd3}) begin errs++; $display("FAIL a1b got v=%b ch=%b hit=%b len=%0d exp v=1 ch=1 hit=0 len=3", res_valid, res_ch, res_hit, res_len); end
      tick();
      send(1, "Q");
      checks++; if ({res_valid, res_hit, res_len} !== {2'b10, 8'd1}) begin errs++; $display("FAIL one_char got v=%b hit=%b len=%0d exp v=1 hit=0 len=1", res_valid, res_hit, res_len); end
      tick();
   endtask

   task automatic test_both();
      int viol = 0;
      int seen = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q.delete();
      fork
         send(0, "ab1");
         send(1, "c9");
         begin
            for (int k = 0; k < 60; k++) begin
               @(negedge clk);
               if (req1_ready) viol++;
               if (res_valid) begin seen = 1; break; end
            end
         end
      join
      repeat (2) tick();
      checks++; if (seen !== 1) begin errs++; $display("FAIL both_first_result got=%0d exp=1", seen); end
      checks++; if (viol !== 0) begin errs++; $display("FAIL both_ready1_during_ch0 got=%0d exp=0", viol); end
      checks++; if (q.size() !== 2) begin errs++; $display("FAIL both_count got=%0d exp=2", q.size()); end
      if (q.size() == 2) begin
         checks++; if ({q[0].ch, q[0].hit, q[0].len} !== {2'b01, 8'd3}) begin errs++; $display("FAIL both_r0 got ch=%b hit=%b len=%0d exp ch=0 hit=1 len=3", q[0].ch, q[0].hit, q[0].len); end
         checks++; if ({q[1].ch, q[1].hit, q[1].len} !== {2'b11, 8'd2}) begin errs++; $display("FAIL both_r1 got ch=%b hit=%b len=%0d exp ch=1 hit=1 len=2", q[1].ch, q[1].hit, q[1].len); end
      end
   endtask

   task automatic test_saturate();
      string s = "x";
      for (int i = 0; i < 299; i++) s = {s, "9"};
      send(0, s);
      checks++; if ({res_valid, res_hit, res_len} !== {2'b11, 8'd255}) begin errs++; $display("FAIL saturate got v=%b hit=%b len=%0d exp v=1 hit=1 len=255", res_valid, res_hit, res_len); end
      tick();
   endtask

   task automatic test_reset_mid();
      int n0;
      int w = 0;
      n0 = q.size();
      drive(0, 1, "a", 0);
      while (!req0_ready && w < 20) begin tick(); w++; end
      tick();
      drive(0, 1, "b", 0);
      tick();
      reset = 1'b1;
      drive(0, 0, 8'h00, 0);
      tick();
      checks++; if ({req0_ready, req1_ready, res_valid, busy, res_hit, res_ch, res_abort} !== 7'b0) begin errs++; $display("FAIL midreset_flags got=%b exp=0000000", {req0_ready, req1_ready, res_valid, busy, res_hit, res_ch, res_abort}); end
      checks++; if (res_len !== 8'd0) begin errs++; $display("FAIL midreset_len got=%0d exp=0", res_len); end
      reset = 1'b0;
      repeat (3) tick();
      checks++; if (q.size() !== n0) begin errs++; $display("FAIL midreset_no_result got=%0d exp=%0d", q.size(), n0); end
      send(0, "z5");
      checks++; if ({res_valid, res_ch, res_hit, res_len} !== {3'b101, 8'd2}) begin errs++; $display("FAIL after_reset got v=%b ch=%b hit=%b len=%0d exp v=1 ch=0 hit=1 len=2", res_valid, res_ch, res_hit, res_len); end
      tick();
   endtask

`ifdef ID_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int w = 0;
      drive(0, 1, "a", 0);
      while (!req0_ready && w < 20) begin tick(); w++; end
      tick();
      drive(0, 0, 8'h00, 0);
      repeat (15) tick();
      checks++; if ({res_valid, busy} !== 2'b01) begin errs++; $display("FAIL to_early got=%b exp=01", {res_valid, busy}); end
      tick();
      checks++; if ({res_valid, res_abort, res_hit, res_ch} !== 4'b1100) begin errs++; $display("FAIL to_flags got=%b exp=1100", {res_valid, res_abort, res_hit, res_ch}); end
      checks++; if (res_len !== 8'd1) begin errs++; $display("FAIL to_len got=%0d exp=1", res_len); end
      tick();
      send(1, "b2");
      checks++; if ({res_valid, res_ch, res_hit, res_abort, res_len} !== {4'b1110, 8'd2}) begin errs++; $display("FAIL to_next got v=%b ch=%b hit=%b ab=%b len=%0d exp 1 1 1 0 2", res_valid, res_ch, res_hit, res_abort, res_len); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single_ch0();
      test_ch1();
      test_both();
      test_saturate();
      test_reset_mid();
`ifdef ID_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/id_arb.md
# id_arb

Round-robin arbiter and sequencer that shares one identifier recognizer between two character-stream requesters. Each requester submits a frame of 8-bit characters over a valid/ready handshake. The block grants one frame at a time, feeds the frame's characters through the recognizer, then reports per-frame results: hit, length and source channel. It sits between the character sources and downstream result consumers.

## Interface
Parameters:
- LEN_W, 8: width of the frame length counter.
- TIMEOUT, 16: stall limit in cycles. Used only with ID_ARB_TIMEOUT_EN.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  channel 0 has a character.
- req0_char  in  8  channel 0 character (ASCII).
- req0_last  in  1  channel 0 character is the last of its frame.
- req0_ready  out  1  channel 0 character accepted this cycle when valid.
- req1_valid / req1_char / req1_last / req1_ready: same as channel 0, for channel 1.
- res_valid  out  1  one-cycle result pulse.
- res_ch  out  1  channel the result belongs to.
- res_hit  out  1  frame ended in recognizer state S2.
- res_len  out  LEN_W  accepted characters in the frame; saturates at 2^LEN_W-1.
- res_abort  out  1  frame terminated by timeout.
- busy  out  1  a frame is granted and in progress.

## Operation
- Character classes:
  - letter: 0x41–0x5A or 0x61–0x7A.
  - digit: 0x30–0x39.
  - other: everything else.
- Recognizer states S0 / S1 / S2. Cleared to S0 when a grant is issued.
  - S0: letter→S1; otherwise stay S0.
  - S1: digit→S2; letter→S1; other→S0.
  - S2: digit→S2; letter→S1; other→S0.
- The recognizer advances only on an accepted character (valid & ready).
- Controller FSM:
  - IDLE: if any reqN_valid, grant a channel, clear the recognizer and length counter, go to BUSY.
  - BUSY: reqN_ready = 1 for the granted channel only. Each accept advances the recognizer and increments the length counter. An accept with last=1 goes to DONE.
  - DONE: res_valid = 1 for exactly one cycle, then go to IDLE.
- Arbitration: a one-bit last_grant pointer.
  - Both channels valid in IDLE: grant the channel not equal to last_grant.
  - Single requester: that channel is granted.
  - last_grant updates on each grant.
- The grant is held for the whole frame. The other channel sees ready=0 even when valid.
- Result registers (res_ch, res_hit, res_len, res_abort) are stable from the DONE cycle until the next DONE.
- res_hit = 1 iff the recognizer state after the last character is S2.
- res_len saturates; it never wraps.
- The result has no backpressure; consumers must sample on res_valid.

## Timing
- Reset values:
  - state IDLE, last_grant = 1 (channel 0 wins first).
  - all ready outputs 0; res_valid, res_ch, res_hit, res_abort 0; res_len 0; busy 0.
- A request seen in IDLE at cycle t gives BUSY and ready high at t+1. The first character is accepted at t+1 at the earliest.
- One character is accepted per cycle at full rate.
- A last accept at cycle t gives res_valid at t+1. IDLE is at t+2; the next grant is at t+2, with its BUSY state at t+3.
- A one-character frame gives res_len = 1.
- Reset asserted mid-frame: the frame is discarded and no result is produced. The next frame starts fresh from IDLE.
- busy = 1 in BUSY and DONE.

## Configuration
- ID_ARB_TIMEOUT_EN defined:
  - In BUSY, a counter increments on each cycle the granted channel's valid is low and clears on any accept.
  - When it reaches TIMEOUT, the FSM goes to DONE with res_abort = 1 and res_hit = 0. res_len is the count accepted so far.
- ID_ARB_TIMEOUT_EN undefined:
  - No counter is built.
  - res_abort is tied to 0.
  - A stalled frame holds the grant indefinitely.

## Structure
- Shared package holds:
  - character-range constants (letter and digit bounds);
  - recognizer state encoding S0/S1/S2;
  - controller state encoding IDLE/BUSY/DONE.
- One sub-module: id_recog.
  - Ports: clk, reset, clr, en, char; output state.
  - Contains the class decode and the S0/S1/S2 register.
- id_arb holds the arbitration, handshake muxing, counters and result registers.

## Test plan
- Reset, then channel 0 sends "ab12" (last on '2') → res_valid one cycle later with res_ch=0, res_hit=1, res_len=4.
- Channel 1 sends "12" → res_hit=0, res_len=2. Channel 1 sends "a1b" → res_hit=0, res_len=3.
- Both channels valid from reset → channel 0 served first, then channel 1. req1_ready stays 0 throughout channel 0's frame, and results arrive in order ch0, ch1.
- A 300-character frame "x" followed by 299 '9's → res_len=255 (saturated), res_hit=1.
- Reset asserted after 2 accepted characters of a frame → no res_valid. All outputs return to reset values the next cycle.
- With ID_ARB_TIMEOUT_EN: channel 0 sends "a", then holds valid low for 16 cycles → res_abort=1, res_hit=0, res_len=1, and channel 1 can then be granted.
